dmem_arbiter: RTL and testbench

//  Two-port arbiter/sequencer in front of the byte-addressed data memory. Shares the single

---
 rtl/dmem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin two-requester arbiter and sequencer for the byte-addressed data memory.
// One transaction in flight: IDLE (accept) -> ACCESS (memory cycle) -> RESP (response pulse).
module dmem_arbiter #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [3:0]            req_size,
  input  logic [1:0]            req_unsigned,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [63:0]           req_wdata,
  output logic [1:0]            resp_valid,
  output logic                  resp_err,
  output logic [31:0]           resp_rdata,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_read_en,
  output logic                  mem_write_byte_en,
  output logic                  mem_write_half_en,
  output logic                  mem_write_word_en,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  typedef logic [ADDR_W:0] addr_ext_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              rd_en_q, rd_en_d;
  logic              wb_q, wb_d;
  logic              wh_q, wh_d;
  logic              ww_q, ww_d;
  logic [1:0]        resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic              grant;
  logic              sel_we;
  logic [1:0]        sel_size;
  logic              sel_uns;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  addr_ext_t         nbytes;
  addr_ext_t         end_addr;
  logic              sel_err;
  logic [31:0]       load_ext;

  // Request selection and checks are done on the incoming request so the
  // memory-side outputs can be registered for the ACCESS cycle.
  always_comb begin
    if (req_valid == 2'b11) begin
      grant = ~last_grant_q;
    end else begin
      grant = req_valid[1];
    end
    sel_we    = grant ? req_we[1]                   : req_we[0];
    sel_size  = grant ? req_size[3:2]               : req_size[1:0];
    sel_uns   = grant ? req_unsigned[1]             : req_unsigned[0];
    sel_addr  = grant ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    sel_wdata = grant ? req_wdata[63:32]            : req_wdata[31:0];
    nbytes    = addr_ext_t'(1) << sel_size;
    end_addr  = {1'b0, sel_addr} + nbytes;
    sel_err   = (sel_size == 2'b11)
              | ((sel_size == 2'b01) & sel_addr[0])
              | ((sel_size == 2'b10) & (|sel_addr[1:0]))
              | (end_addr > addr_ext_t'(MEM_BYTES));
  end

  always_comb begin
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, mem_rdata[7:0]}  : {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      2'b01:   load_ext = uns_q ? {16'h0, mem_rdata[15:0]} : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    err_d        = err_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rd_en_d      = 1'b0;
    wb_d         = 1'b0;
    wh_d         = 1'b0;
    ww_d         = 1'b0;
    resp_valid_d = '0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    req_ready    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          req_ready[grant] = 1'b1;
          last_grant_d     = grant;
          we_d             = sel_we;
          size_d           = sel_size;
          uns_d            = sel_uns;
          err_d            = sel_err;
          mem_addr_d       = sel_addr;
          mem_wdata_d      = sel_wdata;
          state_d          = S_ACCESS;
          if (!sel_err) begin
            rd_en_d = ~sel_we;
            if (sel_we) begin
              wb_d = (sel_size == 2'b00);
              wh_d = (sel_size == 2'b01);
              ww_d = (sel_size == 2'b10);
            end
          end
        end
      end
      S_ACCESS: begin
        state_d                    = S_RESP;
        resp_valid_d[last_grant_q] = 1'b1;
        resp_err_d                 = err_q;
        resp_rdata_d               = (err_q | we_q) ? '0 : load_ext;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      err_q        <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_en_q      <= 1'b0;
      wb_q         <= 1'b0;
      wh_q         <= 1'b0;
      ww_q         <= 1'b0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      err_q        <= err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_en_q      <= rd_en_d;
      wb_q         <= wb_d;
      wh_q         <= wh_d;
      ww_q         <= ww_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp_valid        = resp_valid_q;
  assign resp_err          = resp_err_q;
  assign resp_rdata        = resp_rdata_q;
  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;
  assign mem_read_en       = rd_en_q;
  assign mem_write_byte_en = wb_q;
  assign mem_write_half_en = wh_q;
  assign mem_write_word_en = ww_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed-vector bench for dmem_arbiter with a 1 KiB little-endian byte memory model.
module tb_dmem_arbiter;

  localparam logic [3:0] EN_NONE = 4'b0000;
  localparam logic [3:0] EN_RD   = 4'b1000;
  localparam logic [3:0] EN_WB   = 4'b0100;
  localparam logic [3:0] EN_WH   = 4'b0010;
  localparam logic [3:0] EN_WW   = 4'b0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [3:0]  req_size;
  logic [1:0]  req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read_en;
  logic        mem_write_byte_en;
  logic        mem_write_half_en;
  logic        mem_write_word_en;
  logic [31:0] mem_rdata;
  logic [3:0]  en;

  logic [7:0]  mem [0:1023] = '{default: 8'h00};
  int          resp_pulses = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(1024), .ADDR_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_we            (req_we),
    .req_size          (req_size),
    .req_unsigned      (req_unsigned),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_err          (resp_err),
    .resp_rdata        (resp_rdata),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_read_en       (mem_read_en),
    .mem_write_byte_en (mem_write_byte_en),
    .mem_write_half_en (mem_write_half_en),
    .mem_write_word_en (mem_write_word_en),
    .mem_rdata         (mem_rdata)
  );

  assign en = {mem_read_en, mem_write_byte_en, mem_write_half_en, mem_write_word_en};

  always_comb begin
    mem_rdata = '0;
    for (int k = 0; k < 4; k++) begin
      if (mem_addr + 32'(k) < 32'd1024) mem_rdata[8*k +: 8] = mem[mem_addr[9:0] + 10'(k)];
    end
  end

  always @(posedge clk) begin
    if (mem_write_word_en) begin
      for (int k = 0; k < 4; k++) mem[mem_addr[9:0] + 10'(k)] <= mem_wdata[8*k +: 8];
    end else if (mem_write_half_en) begin
      for (int k = 0; k < 2; k++) mem[mem_addr[9:0] + 10'(k)] <= mem_wdata[8*k +: 8];
    end else if (mem_write_byte_en) begin
      mem[mem_addr[9:0]] <= mem_wdata[7:0];
    end
  end

  always @(negedge clk) begin
    if (|resp_valid) resp_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Called at posedge+1; returns at posedge+1 of the IDLE cycle after the response.
  task automatic xact(input string tag, input int p, input logic we, input logic [1:0] sz,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] exp_en, input logic exp_err, input logic [31:0] exp_rdata);
    int waited = 0;
    req_we[p]            = we;
    req_size[2*p +: 2]   = sz;
    req_unsigned[p]      = uns;
    req_addr[32*p +: 32] = addr;
    req_wdata[32*p +: 32] = wdata;
    req_valid[p]         = 1'b1;
    #1;
    while (!req_ready[p] && waited < 8) begin
      @(posedge clk); #2;
      waited++;
    end
    check({tag, " ready"}, 32'(req_ready[p]), 32'd1);
    if (!req_ready[p]) begin
      req_valid[p] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    check({tag, " access ready"}, 32'(req_ready), 32'd0);
    check({tag, " access en"}, 32'(en), 32'(exp_en));
    check({tag, " access addr"}, mem_addr, addr);
    if (exp_en != EN_NONE && we) check({tag, " access wdata"}, mem_wdata, wdata);
    @(posedge clk); #1;
    check({tag, " resp_valid"}, 32'(resp_valid), 32'(2'b01 << p));
    check({tag, " resp_err"}, 32'(resp_err), 32'(exp_err));
    check({tag, " resp_rdata"}, resp_rdata, exp_rdata);
    check({tag, " resp en"}, 32'(en), 32'd0);
    @(posedge clk); #1;
    check({tag, " resp done"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int pulses_before;
    rst = 1'b1;
    req_valid = '0;
    req_we = '0;
    req_size = '0;
    req_unsigned = '0;
    req_addr = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst ready", 32'(req_ready), 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_err", 32'(resp_err), 32'd0);
    check("rst rdata", resp_rdata, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst en", 32'(en), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Word store/load round trip
    xact("st_w10", 0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, EN_WW, 1'b0, 32'h0);
    xact("ld_w10", 0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, EN_RD, 1'b0, 32'hDEADBEEF);

    // Byte/half extension
    xact("st_b21", 0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h00000080, EN_WB, 1'b0, 32'h0);
    xact("ld_b21s", 0, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, EN_RD, 1'b0, 32'hFFFFFF80);
    xact("ld_b21u", 0, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, EN_RD, 1'b0, 32'h00000080);
    xact("ld_h20u", 0, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, EN_RD, 1'b0, 32'h00008000);
    xact("ld_h20s", 1, 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, EN_RD, 1'b0, 32'hFFFF8000);

    // Continuous contention alternates grants starting at requester 0 after reset
    do_reset();
    req_we = 2'b00;
    req_size = {2'b01, 2'b10};
    req_unsigned = 2'b10;
    req_addr = {32'h20, 32'h10};
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr grant", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      @(posedge clk); #1;
      check("rr access ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      check("rr resp_valid", 32'(resp_valid), (k % 2 == 0) ? 32'd1 : 32'd2);
      check("rr rdata", resp_rdata, (k % 2 == 0) ? 32'hDEADBEEF : 32'h00008000);
      @(posedge clk); #1;
    end
    req_valid = '0;
    req_unsigned = '0;

    // Error cases: misaligned, illegal size, out of range
    xact("err_w13", 0, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, EN_NONE, 1'b1, 32'h0);
    xact("err_h05", 0, 1'b1, 2'b01, 1'b0, 32'h05, 32'h0000ABCD, EN_NONE, 1'b1, 32'h0);
    xact("err_sz3", 0, 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, EN_NONE, 1'b1, 32'h0);
    xact("err_w3fe", 0, 1'b0, 2'b10, 1'b0, 32'h3FE, 32'h0, EN_NONE, 1'b1, 32'h0);
    check("err mem05", 32'(mem[5]), 32'h0);
    check("err mem06", 32'(mem[6]), 32'h0);

    // Reset during the ACCESS cycle of a store
    pulses_before = resp_pulses;
    req_we[0] = 1'b1;
    req_size[1:0] = 2'b10;
    req_addr[31:0] = 32'h40;
    req_wdata[31:0] = 32'hCAFEF00D;
    req_valid = 2'b01;
    #1;
    check("rst_mid ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("rst_mid access en", 32'(en), 32'(EN_WW));
    req_valid = '0;
    rst = 1'b1;
    #1;
    check("rst_mid en", 32'(en), 32'd0);
    check("rst_mid mem_addr", mem_addr, 32'd0);
    check("rst_mid mem_wdata", mem_wdata, 32'd0);
    check("rst_mid resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid mem40", {mem[16'h43], mem[16'h42], mem[16'h41], mem[16'h40]}, 32'h0);
    check("rst_mid no resp", 32'(resp_pulses - pulses_before), 32'd0);
    req_we = '0;
    req_valid = 2'b11;
    #1;
    check("rst_mid first grant", 32'(req_ready), 32'd1);
    req_valid = '0;
    @(posedge clk); #1;

    // Upper boundary of the memory
    xact("st_w3fc", 1, 1'b1, 2'b10, 1'b0, 32'h3FC, 32'h11223344, EN_WW, 1'b0, 32'h0);
    xact("ld_w3fc", 0, 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, EN_RD, 1'b0, 32'h11223344);
    xact("ld_b3ff", 0, 1'b0, 2'b00, 1'b0, 32'h3FF, 32'h0, EN_RD, 1'b0, 32'h00000011);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
